regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised register file for the multicycle datapath. Replaces the fixed 16×32 array: two combinational read ports, one clocked write port with the writeback mux (ALU/memory) and destination select (rd/rt) built in, an optional hard-wired zero register, optional write-to-read bypass, and the A/B operand latches. It also provides a sequential bulk-clear engine. It sits between instruction decode (rs/rt/rd) and the ALU operand muxes.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register-address width
- DEPTH, 32, number of implemented registers; legal range 2..2^ADDR_W
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes
- BYPASS, 1, 1 = same-cycle write data forwarded to the read ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rs, rt, rd  in  ADDR_W  source/source-or-dest/dest addresses
- reg_write  in  1  write enable
- reg_dst  in  1  1 = write to rd, 0 = write to rt
- mem_to_reg  in  1  1 = write mem_data, 0 = write alu_data
- mem_data, alu_data  in  DATA_W  writeback sources
- ab_en  in  1  load a_q/b_q this cycle
- clr_req  in  1  start a bulk clear (level sampled while idle)
- read_data_1, read_data_2  out  DATA_W  combinational read of rs, rt
- a_q, b_q  out  DATA_W  registered operands
- busy  out  1  clear engine active
- clr_done  out  1  one-cycle pulse on the final clear cycle

## Operation
- waddr = reg_dst ? rd : rt; wdata = mem_to_reg ? mem_data : alu_data.
- A write commits when all of the following hold: reg_write=1, busy=0, waddr<DEPTH, and not (ZERO_REG=1 and waddr=0). Otherwise the write is dropped silently.
- Read port value, first matching rule wins:
  - busy=1 -> 0
  - addr≥DEPTH -> 0
  - ZERO_REG and addr=0 -> 0
  - BYPASS and the write commits this cycle and addr=waddr -> wdata
  - otherwise -> array[addr]
- ab_en=1: a_q<=read_data_1 and b_q<=read_data_2 at the clock edge, including bypassed values. ab_en=0: a_q/b_q hold.
- Clear FSM, two states:
  - IDLE: clr_req=1 -> CLEAR, idx<=0, busy<=1.
  - CLEAR: array[idx]<=0 and idx<=idx+1 each cycle. When idx=DEPTH-1, clr_done=1 in that cycle, and the next state is IDLE with busy<=0.
- clr_req while busy is ignored. If clr_req is still high in the cycle after returning to IDLE, a new clear starts.
- idx is ceil(log2 DEPTH) bits wide; no wrap-around beyond DEPTH-1.

## Timing
- Reset (rst_n=0, asynchronous): all DEPTH entries=0, a_q=b_q=0, busy=0, clr_done=0, FSM=IDLE, idx=0. The read ports therefore show 0.
- Reset asserted mid-clear aborts the clear immediately; the array is still fully zeroed by reset.
- Release of rst_n is synchronised by the system; the first write can commit at the first rising edge after release.
- Write latency: the value written at edge N is visible from array reads after edge N. With BYPASS=1 it is also visible combinationally in the cycle before edge N. With BYPASS=0, a same-cycle read returns the old value.
- Clear latency: clr_req sampled at edge N gives busy=1 after edge N. busy falls after edge N+DEPTH. clr_done is high during the cycle ending at edge N+DEPTH.
- Simultaneous reg_write and clr_req in IDLE: the write commits at the same edge the clear starts; the clear later overwrites it with 0.
- rs=rt: both ports return the same value. waddr=rs=rt with bypass: both ports are forwarded.

## Test plan
- Reset: preload via writes, then pulse rst_n low mid-cycle (no clock edge) -> every entry reads 0, and a_q=b_q=busy=0 immediately.
- Writeback mux: reg_dst=1, rd=5, mem_to_reg=1, mem_data=0xDEADBEEF; then reg_dst=0, rt=6, alu_data=0x12345678 -> r5=0xDEADBEEF, r6=0x12345678, all other entries unchanged.
- Zero register and out-of-range: write 0xFFFFFFFF to r0 -> reads 0. With DEPTH=16, ADDR_W=5, write to r20 -> dropped, and rs=20 reads 0.
- Bypass: BYPASS=1, write 0xA5A5A5A5 to r7 with rs=rt=7 and ab_en=1 -> read_data_1/2=0xA5A5A5A5 in the same cycle, a_q=b_q=0xA5A5A5A5 after the edge. With BYPASS=0, the same stimulus yields the old r7 value.
- Bulk clear: fill r1..r31 with nonzero values, pulse clr_req -> busy high for exactly 32 cycles, clr_done pulses once, reads return 0 while busy, writes issued while busy are dropped, all entries are 0 afterwards.
- Reset mid-clear: assert rst_n low at clear cycle 10 -> busy=0 at once, all entries 0, and a fresh clr_req after release clears normally.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp
// ----------
// Parametrised register file for the multicycle datapath. It sits between
// instruction decode (rs/rt/rd) and the ALU operand muxes.
//
// Ports:
//   clk, rst_n                 clock (rising edge) and async active-low reset
//   rs, rt, rd                 source / source-or-dest / dest addresses
//   reg_write                  write enable
//   reg_dst                    1 = write to rd, 0 = write to rt
//   mem_to_reg                 1 = write mem_data, 0 = write alu_data
//   mem_data, alu_data         writeback sources
//   ab_en                      load a_q/b_q from the read ports this cycle
//   clr_req                    start a bulk clear (sampled while idle)
//   read_data_1, read_data_2   combinational reads of rs and rt
//   a_q, b_q                   registered operand latches
//   busy                       bulk-clear engine active
//   clr_done                   one-cycle pulse during the final clear cycle
//
// Parameters:
//   DATA_W    register width
//   ADDR_W    address width
//   DEPTH     implemented registers, 2..2**ADDR_W
//   ZERO_REG  1 = register 0 reads 0 and ignores writes
//   BYPASS    1 = a committing write is forwarded to the read ports
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic              reg_write,
  input  logic              reg_dst,
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ab_en,
  input  logic              clr_req,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic [DATA_W-1:0] a_q,
  output logic [DATA_W-1:0] b_q,
  output logic              busy,
  output logic              clr_done
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(DEPTH - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              busy_q;
  logic              clr_done_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              wcommit;

  // Writeback muxes and the commit qualifier. A write is dropped while the
  // clear engine owns the array, when it targets an unimplemented entry, or
  // when it targets the hard-wired zero register.
  always_comb begin
    waddr   = reg_dst ? rd : rt;
    wdata   = mem_to_reg ? mem_data : alu_data;
    wcommit = reg_write && !busy_q && (int'(waddr) < DEPTH) &&
              !((ZERO_REG != 0) && (waddr == '0));
  end

  // Read ports. The rules are applied lowest priority first so that later
  // assignments override: array, bypass, zero register, busy. Addresses at or
  // beyond DEPTH never match the array loop and therefore read 0; a bypass
  // can only fire for an in-range address because wcommit requires it.
  always_comb begin
    read_data_1 = '0;
    read_data_2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rs == ADDR_W'(i)) read_data_1 = mem_q[i];
      if (rt == ADDR_W'(i)) read_data_2 = mem_q[i];
    end
    if ((BYPASS != 0) && wcommit) begin
      if (rs == waddr) read_data_1 = wdata;
      if (rt == waddr) read_data_2 = wdata;
    end
    if ((ZERO_REG != 0) && (rs == '0)) read_data_1 = '0;
    if ((ZERO_REG != 0) && (rt == '0)) read_data_2 = '0;
    if (busy_q) begin
      read_data_1 = '0;
      read_data_2 = '0;
    end
  end

  // Register array. While clearing, the entry selected by idx is zeroed each
  // cycle; otherwise a committing write updates its target entry. Reset
  // zeroes every entry, which also covers a clear aborted by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (state_q == CLEAR) begin
          if (idx_q == IDX_W'(i)) mem_q[i] <= '0;
        end else if (wcommit && (waddr == ADDR_W'(i))) begin
          mem_q[i] <= wdata;
        end
      end
    end
  end

  // Bulk-clear FSM. busy and clr_done are registered: clr_done is raised on
  // the edge that moves idx onto the last entry so it is high exactly during
  // the final clear cycle. idx stops at the last entry instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          clr_done_q <= 1'b0;
          if (clr_req) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (idx_q == LAST_IDX) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
          end else begin
            idx_q      <= idx_q + 1'b1;
            clr_done_q <= (idx_q == PENULT_IDX);
          end
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Operand latches capture the read ports, bypassed values included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (ab_en) begin
      a_q <= read_data_1;
      b_q <= read_data_2;
    end
  end

  assign busy     = busy_q;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// -------------
// Testbench for regfile_mp. Two instances share one set of inputs:
//   dut0: DEPTH=32, ZERO_REG=1, BYPASS=1
//   dut1: DEPTH=16, ZERO_REG=0, BYPASS=0
// Inputs change on the falling edge; outputs are compared 1 time unit later
// against a behavioural model, which advances on every rising edge.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs, rt, rd;
  logic        reg_write, reg_dst, mem_to_reg, ab_en, clr_req;
  logic [31:0] mem_data, alu_data;

  logic [31:0] r1_0, r2_0, a_0, b_0, r1_1, r2_1, a_1, b_1;
  logic        busy_0, done_0, busy_1, done_1;

  int errors = 0;
  int checks = 0;

  // Model state, index 0 = dut0, index 1 = dut1.
  logic [31:0] mm [2][32];
  logic [31:0] ma [2];
  logic [31:0] mb [2];
  int          rem [2];
  int          dep [2];
  bit          zr [2];
  bit          byp [2];

  always #50 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rd(rd),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .mem_data(mem_data), .alu_data(alu_data), .ab_en(ab_en), .clr_req(clr_req),
    .read_data_1(r1_0), .read_data_2(r2_0), .a_q(a_0), .b_q(b_0),
    .busy(busy_0), .clr_done(done_0)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .ZERO_REG(0), .BYPASS(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rd(rd),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .mem_data(mem_data), .alu_data(alu_data), .ab_en(ab_en), .clr_req(clr_req),
    .read_data_1(r1_1), .read_data_2(r2_1), .a_q(a_1), .b_q(b_1),
    .busy(busy_1), .clr_done(done_1)
  );

  // Model helpers: destination address, commit decision and read value,
  // written directly from the behavioural rules of the register file.
  function automatic logic [4:0] mWaddr();
    return reg_dst ? rd : rt;
  endfunction

  function automatic logic [31:0] mWdata();
    return mem_to_reg ? mem_data : alu_data;
  endfunction

  function automatic bit mCommits(input int k);
    logic [4:0] wa;
    wa = mWaddr();
    return reg_write && (rem[k] == 0) && (int'(wa) < dep[k]) && !(zr[k] && wa == 5'd0);
  endfunction

  function automatic logic [31:0] mRead(input int k, input logic [4:0] addr);
    if (rem[k] > 0) return 32'd0;
    if (int'(addr) >= dep[k]) return 32'd0;
    if (zr[k] && addr == 5'd0) return 32'd0;
    if (byp[k] && mCommits(k) && addr == mWaddr()) return mWdata();
    return mm[k][addr];
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) mm[k][i] = 32'd0;
      ma[k] = 32'd0;
      mb[k] = 32'd0;
      rem[k] = 0;
    end
  endtask

  // One rising edge of the model. rem counts the clear cycles still to go.
  task automatic modelEdge();
    logic [31:0] ra, rb;
    bit c;
    for (int k = 0; k < 2; k++) begin
      ra = mRead(k, rs);
      rb = mRead(k, rt);
      c  = mCommits(k);
      if (ab_en) begin
        ma[k] = ra;
        mb[k] = rb;
      end
      if (rem[k] > 0) begin
        mm[k][dep[k] - rem[k]] = 32'd0;
        rem[k] = rem[k] - 1;
      end else begin
        if (c) mm[k][mWaddr()] = mWdata();
        if (clr_req) rem[k] = dep[k];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, "/d0/rd1"},  r1_0, mRead(0, rs));
    chk({tag, "/d0/rd2"},  r2_0, mRead(0, rt));
    chk({tag, "/d0/a"},    a_0, ma[0]);
    chk({tag, "/d0/b"},    b_0, mb[0]);
    chk({tag, "/d0/busy"}, 32'(busy_0), 32'(rem[0] > 0));
    chk({tag, "/d0/done"}, 32'(done_0), 32'(rem[0] == 1));
    chk({tag, "/d1/rd1"},  r1_1, mRead(1, rs));
    chk({tag, "/d1/rd2"},  r2_1, mRead(1, rt));
    chk({tag, "/d1/a"},    a_1, ma[1]);
    chk({tag, "/d1/b"},    b_1, mb[1]);
    chk({tag, "/d1/busy"}, 32'(busy_1), 32'(rem[1] > 0));
    chk({tag, "/d1/done"}, 32'(done_1), 32'(rem[1] == 1));
  endtask

  // Drive one cycle of inputs at the falling edge, check, then clock it.
  task automatic applyStimulus(input logic [4:0] s_rs, input logic [4:0] s_rt,
                               input logic [4:0] s_rd, input logic s_we,
                               input logic s_dst, input logic s_m2r,
                               input logic [31:0] s_md, input logic [31:0] s_ad,
                               input logic s_ab, input logic s_clr, input string tag);
    rs = s_rs; rt = s_rt; rd = s_rd;
    reg_write = s_we; reg_dst = s_dst; mem_to_reg = s_m2r;
    mem_data = s_md; alu_data = s_ad; ab_en = s_ab; clr_req = s_clr;
    #1;
    checkOutput(tag);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic randStep(input bit allow_clr, input string tag);
    logic [4:0] s_rt, s_rd, s_rs, s_rt_rd, wa;
    logic       s_dst;
    s_rd  = 5'($urandom);
    s_rt  = 5'($urandom);
    s_dst = 1'($urandom);
    wa    = s_dst ? s_rd : s_rt;
    s_rs  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
    s_rt_rd = (!s_dst || $urandom_range(0, 3) != 0) ? s_rt : wa;
    applyStimulus(s_rs, s_rt_rd, s_rd, 1'($urandom), s_dst, 1'($urandom),
                  $urandom, $urandom, 1'($urandom),
                  allow_clr && ($urandom_range(0, 24) == 0), tag);
  endtask

  // Read every address on both ports without a clock edge in between.
  task automatic sweep(input string tag);
    reg_write = 1'b0; ab_en = 1'b0; clr_req = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rs = 5'(a);
      rt = 5'(31 - a);
      #1;
      chk({tag, "/d0/rd1"}, r1_0, mRead(0, rs));
      chk({tag, "/d0/rd2"}, r2_0, mRead(0, rt));
      chk({tag, "/d1/rd1"}, r1_1, mRead(1, rs));
      chk({tag, "/d1/rd2"}, r2_1, mRead(1, rt));
    end
  endtask

  task automatic idleEdge();
    reg_write = 1'b0; ab_en = 1'b0; clr_req = 1'b0;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  // Reset pulse placed between edges, with a full readout while it is low.
  task automatic resetPulse(input string tag);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput(tag);
    chk({tag, "/d0/busy0"}, 32'(busy_0), 32'd0);
    chk({tag, "/d0/a0"}, a_0, 32'd0);
    sweep(tag);
    rst_n = 1'b1;
    idleEdge();
  endtask

  initial begin
    dep = '{32, 16};
    zr  = '{1'b1, 1'b0};
    byp = '{1'b1, 1'b0};
    rst_n = 1'b0;
    rs = '0; rt = '0; rd = '0;
    reg_write = 1'b0; reg_dst = 1'b0; mem_to_reg = 1'b0;
    mem_data = '0; alu_data = '0; ab_en = 1'b0; clr_req = 1'b0;
    modelReset();
    #1;
    $display("[TB] reset state");
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] writeback mux");
    applyStimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h0BADF00D, 1'b0, 1'b0, "wb_rd_mem");
    applyStimulus(5'd6, 5'd6, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0BADF00D, 32'h12345678, 1'b0, 1'b0, "wb_rt_alu");
    reg_write = 1'b0; rs = 5'd5; rt = 5'd6;
    #1;
    chk("wb_r5_d0", r1_0, 32'hDEADBEEF);
    chk("wb_r6_d0", r2_0, 32'h12345678);
    chk("wb_r5_d1", r1_1, 32'hDEADBEEF);
    chk("wb_r6_d1", r2_1, 32'h12345678);
    sweep("wb_sweep");
    idleEdge();

    $display("[TB] random writes");
    for (int i = 0; i < 40; i++) randStep(1'b0, "rand_wr");
    sweep("rand_wr_sweep");
    idleEdge();

    $display("[TB] zero register and out of range");
    applyStimulus(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, "zero_wr");
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "zero_rd");
    chk("zero_r0_d0", r1_0, 32'd0);
    chk("zero_r0_d1", r1_1, 32'hFFFFFFFF);
    applyStimulus(5'd20, 5'd20, 5'd20, 1'b1, 1'b1, 1'b1, 32'h5555AAAA, 32'd0, 1'b0, 1'b0, "oor_wr");
    applyStimulus(5'd20, 5'd20, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "oor_rd");
    chk("oor_r20_d1", r1_1, 32'd0);
    chk("oor_r20_d0", r1_0, 32'h5555AAAA);

    $display("[TB] bypass");
    applyStimulus(5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 32'd0, 32'h11111111, 1'b0, 1'b0, "byp_pre");
    rs = 5'd7; rt = 5'd7; rd = 5'd7; reg_write = 1'b1; reg_dst = 1'b1;
    mem_to_reg = 1'b0; alu_data = 32'hA5A5A5A5; ab_en = 1'b1;
    #1;
    chk("byp_rd1_d0", r1_0, 32'hA5A5A5A5);
    chk("byp_rd2_d0", r2_0, 32'hA5A5A5A5);
    chk("byp_rd1_d1", r1_1, 32'h11111111);
    applyStimulus(5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 32'd0, 32'hA5A5A5A5, 1'b1, 1'b0, "byp_wr");
    applyStimulus(5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "byp_post");
    chk("byp_a_d0", a_0, 32'hA5A5A5A5);
    chk("byp_b_d0", b_0, 32'hA5A5A5A5);
    chk("byp_a_d1", a_1, 32'h11111111);
    chk("byp_r7_d1", r1_1, 32'hA5A5A5A5);

    $display("[TB] reset with preloaded contents");
    resetPulse("rst_preload");

    $display("[TB] bulk clear");
    for (int i = 1; i < 32; i++)
      applyStimulus(5'(i), 5'(i), 5'(i), 1'b1, 1'b1, 1'($urandom),
                    $urandom | 32'd1, $urandom | 32'd1, 1'b0, 1'b0, "fill");
    sweep("fill_sweep");
    idleEdge();
    applyStimulus(5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 32'd0, 32'h77777777, 1'b1, 1'b1, "clr_start");
    for (int i = 0; i < 34; i++) randStep(1'b0, "clr_busy");
    sweep("clr_sweep");
    idleEdge();

    $display("[TB] reset mid-clear");
    applyStimulus(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, "mid_start");
    for (int i = 0; i < 10; i++) randStep(1'b0, "mid_busy");
    resetPulse("rst_midclr");
    for (int i = 0; i < 8; i++) randStep(1'b0, "post_rst_wr");
    applyStimulus(5'd4, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, "fresh_start");
    for (int i = 0; i < 34; i++) randStep(1'b0, "fresh_busy");
    sweep("fresh_sweep");
    idleEdge();

    $display("[TB] clear request held high");
    for (int i = 0; i < 40; i++)
      applyStimulus(5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b0,
                    32'd0, $urandom, 1'($urandom), 1'b1, "clr_held");
    for (int i = 0; i < 34; i++) randStep(1'b0, "clr_drain");

    $display("[TB] random mix");
    for (int i = 0; i < 150; i++) randStep(1'b1, "mix");
    sweep("mix_sweep");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
